// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel push-button debouncer with edge and hold-to-repeat pulses
// Per channel: 2-FF synchroniser, symmetric stable-count filter, registered rise/fall, optional repeat.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam logic [RC_W-1:0] RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic {
    RPT_WAIT_DELAY,
    RPT_WAIT_PERIOD
  } rpt_state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1_q;
    logic             s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q   <= 1'b0;
        s_q    <= 1'b0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s1_q   <= btn[i];
        s_q    <= s1_q;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the qualification.
    always_comb begin
      cnt_d  = '0;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s_q != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d  = s_q;
          rise_d = s_q;
          fall_d = ~s_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

    if (REPEAT_EN != 0) begin : g_rpt
      rpt_state_e      st_q;
      rpt_state_e      st_d;
      logic [RC_W-1:0] rc_q;
      logic [RC_W-1:0] rc_d;
      logic            rpt_q;
      logic            rpt_d;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st_q  <= RPT_WAIT_DELAY;
          rc_q  <= '0;
          rpt_q <= 1'b0;
        end else begin
          st_q  <= st_d;
          rc_q  <= rc_d;
          rpt_q <= rpt_d;
        end
      end

      // The rise edge sees lvl_q low, so it clears rc; the fall edge suppresses any due repeat.
      always_comb begin
        st_d  = st_q;
        rc_d  = '0;
        rpt_d = 1'b0;
        if (!lvl_q || fall_d) begin
          st_d = RPT_WAIT_DELAY;
        end else begin
          case (st_q)
            RPT_WAIT_DELAY: begin
              if (rc_q == RC_DELAY_LAST) begin
                rpt_d = 1'b1;
                st_d  = RPT_WAIT_PERIOD;
              end else begin
                rc_d = rc_q + 1'b1;
              end
            end
            default: begin
              if (rc_q == RC_PERIOD_LAST) begin
                rpt_d = 1'b1;
              end else begin
                rc_d = rc_q + 1'b1;
              end
            end
          endcase
        end
      end

      assign rpt[i] = rpt_q;
    end else begin : g_no_rpt
      assign rpt[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed and randomized checks of debounce_multi against a window/time model
// The model accepts a level once the last STABLE_CYCLES synchronised samples all oppose it.
module tb_debounce_multi;
  localparam int N  = 4;
  localparam int S  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn   = '0;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] rpt;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(N), .STABLE_CYCLES(S), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .level(level), .rise(rise), .fall(fall), .rpt(rpt)
  );

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;

  logic [N-1:0] m_s1, m_s, m_level, e_rise, e_fall, e_rpt;
  logic [N-1:0] hist[$];
  int           rise_at[N];

  int k, first, first2, cnt_a, cnt_b, cnt_c, after_fall;
  logic [N-1:0] cap_a, cap_b;
  int hold[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_s1    = '0;
    m_s     = '0;
    m_level = '0;
    e_rise  = '0;
    e_fall  = '0;
    e_rpt   = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    e_rise = '0;
    e_fall = '0;
    e_rpt  = '0;
    if (reset) begin
      model_clear();
      return;
    end
    hist.push_back(m_s);
    if (hist.size() > S) void'(hist.pop_front());
    for (int i = 0; i < N; i++) begin
      bit stable;
      int d;
      stable = (hist.size() == S);
      foreach (hist[j]) if (hist[j][i] == m_level[i]) stable = 1'b0;
      if (stable) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          e_rise[i]  = 1'b1;
          rise_at[i] = ecnt;
        end else begin
          e_fall[i] = 1'b1;
        end
      end else if (m_level[i]) begin
        d = ecnt - rise_at[i];
        if (d == RD || (d > RD && (d - RD) % RP == 0)) e_rpt[i] = 1'b1;
      end
    end
    m_s  = m_s1;
    m_s1 = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    ecnt++;
    #1;
    check("level", level, m_level);
    check("rise", rise, e_rise);
    check("fall", fall, e_fall);
    check("rpt", rpt, e_rpt);
    @(negedge clk);
  endtask

  task automatic pulse_reset(input logic [N-1:0] btn_during);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check("async_rst_outputs", {level, rise, fall, rpt}, 16'h0);
    btn = btn_during;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (3) tick();
    check("rst_outputs", {level, rise, fall, rpt}, 16'h0);
    reset = 1'b0;
    tick();
    check("first_after_rst", {level, rise, fall, rpt}, 16'h0);

    // Clean step on channel 0
    btn = 4'b0001;
    k = ecnt;
    first = -1;
    repeat (14) begin
      tick();
      if (rise[0] && first < 0) first = ecnt - 1;
      check("t1_others", {level[3:1], rise[3:1]}, 6'h0);
    end
    check("t1_rise_edge", first, k + 9);
    btn = 4'b0000;
    repeat (14) tick();

    // Glitch of 7 samples is rejected, 8 accepted
    cnt_a = 0;
    btn[1] = 1'b1;
    repeat (7) tick();
    btn[1] = 1'b0;
    repeat (14) begin
      tick();
      cnt_a += int'(level[1]) + int'(rise[1]) + int'(fall[1]);
    end
    check("t2_glitch", cnt_a, 0);
    cnt_a = 0;
    cnt_b = 0;
    btn[1] = 1'b1;
    repeat (8) begin tick(); cnt_a += int'(rise[1]); cnt_b += int'(fall[1]); end
    btn[1] = 1'b0;
    repeat (20) begin tick(); cnt_a += int'(rise[1]); cnt_b += int'(fall[1]); end
    check("t2_rise_cnt", cnt_a, 1);
    check("t2_fall_cnt", cnt_b, 1);

    // Bounce then settle on channel 2
    cnt_a = 0;
    for (int c = 0; c < 30; c++) begin
      btn[2] = ((c / 3) % 2 == 0);
      tick();
      cnt_a += int'(rise[2]);
    end
    btn[2] = 1'b1;
    k = ecnt;
    first = -1;
    repeat (20) begin
      tick();
      cnt_a += int'(rise[2]);
      if (rise[2] && first < 0) first = ecnt - 1;
    end
    check("t3_rise_cnt", cnt_a, 1);
    check("t3_rise_edge", first, k + 9);
    cnt_b = 0;
    for (int c = 0; c < 30; c++) begin
      btn[2] = ((c / 3) % 2 == 1);
      tick();
      cnt_b += int'(fall[2]);
    end
    btn[2] = 1'b0;
    repeat (20) begin tick(); cnt_b += int'(fall[2]); end
    check("t3_fall_cnt", cnt_b, 1);

    // Hold-to-repeat on channel 3
    btn[3] = 1'b1;
    first = -1;
    first2 = -1;
    cnt_a = 0;
    repeat (60) begin
      tick();
      if (rise[3] && first < 0) first = ecnt - 1;
      if (rpt[3] && first2 < 0) first2 = ecnt - 1;
      cnt_a += int'(rpt[3]);
    end
    check("t4_first_rpt", first2 - first, RD);
    check("t4_rpt_cnt", cnt_a, 7);
    btn[3] = 1'b0;
    after_fall = 0;
    cnt_b = 0;
    cnt_c = 0;
    repeat (14) begin
      tick();
      if (fall[3]) begin after_fall = 1; cnt_c++; end
      if (after_fall != 0) cnt_b += int'(rpt[3]);
    end
    check("t4_fall_cnt", cnt_c, 1);
    check("t4_rpt_after_fall", cnt_b, 0);
    repeat (4) tick();

    // Simultaneous channels
    btn = 4'b1111;
    cap_a = '0;
    cnt_a = 0;
    repeat (14) begin
      tick();
      if (rise != '0) begin cap_a = rise; cnt_a++; end
    end
    check("t5_rise_vec", cap_a, 4'b1111);
    check("t5_rise_cycles", cnt_a, 1);
    btn = 4'b0101;
    cap_b = '0;
    repeat (14) begin
      tick();
      if (fall != '0) cap_b = fall;
    end
    check("t5_fall_vec", cap_b, 4'b1010);
    check("t5_level", level, 4'b0101);

    // Async reset mid-count with a held button
    btn = 4'b1000;
    repeat (14) tick();
    check("t6_pre_level", level, 4'b1000);
    btn = 4'b1001;
    repeat (7) tick();
    pulse_reset(4'b1000);
    k = ecnt;
    first = -1;
    cnt_a = 0;
    repeat (14) begin
      tick();
      if (rise[3] && first < 0) first = ecnt - 1;
      cnt_a += int'(rise[0]);
    end
    check("t6_rerise_edge", first, k + 9);
    check("t6_no_ch0", cnt_a, 0);

    // Randomized hold lengths, mixing glitches and long holds
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 20);
    repeat (2000) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn[i]  = ~btn[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 45) : $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 399) == 0) pulse_reset(btn);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised N-channel push-button debouncer for board inputs feeding the VGA controller's control logic. Each channel has:
- a 2-FF synchroniser
- a symmetric press/release debouncer, so the level is filtered in both directions
- one-cycle press/release pulses
- optional hold-to-repeat pulses for cursor and colour stepping

All channels are independent and share one clock and one reset.

Parameters:
N_CH, 4, number of independent button channels (>=1)
STABLE_CYCLES, 100000, consecutive mismatching synchronised samples required to accept a new level (>=2)
REPEAT_EN, 0, 1 enables hold-to-repeat pulses; 0 ties rpt to 0
REPEAT_DELAY, 50000000, cycles from accepted press to first repeat pulse (>=1)
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
btn  input  N_CH  raw asynchronous button levels, bit i = channel i
level  output  N_CH  debounced level per channel
rise  output  N_CH  one-cycle pulse on accepted 0->1 transition
fall  output  N_CH  one-cycle pulse on accepted 1->0 transition
rpt  output  N_CH  one-cycle repeat pulse while level held high (REPEAT_EN=1)

Behaviour:
Reset:
- reset high asynchronously clears: sync stages, level, rise, fall, rpt, all counters.
- All outputs are 0 during reset and in the first cycle after release.
- Reset mid-count discards the partial count. A held button is re-qualified from zero after reset.

Synchroniser:
- s1[i] <= btn[i]; s[i] <= s1[i].
- btn sampled at edge k appears on s at edge k+1.

Debounce counter:
- Per channel, width CNT_W = $clog2(STABLE_CYCLES).
- Each edge with s[i] == level[i]: cnt[i] <= 0.
- Each edge with s[i] != level[i]: if cnt[i] == STABLE_CYCLES-1, then level[i] <= s[i] and cnt[i] <= 0; otherwise cnt[i] increments.
- Latency: a clean step first sampled at edge k updates level at edge k+1+STABLE_CYCLES.
- Any return to the old level before the count completes clears cnt. No output change, no pulse.
- Rule is symmetric for press and release.
- Counter never wraps. Saturation is impossible because the counter clears at terminal.

Edge pulses:
- rise and fall are registered and asserted on the same edge that level changes, for exactly one cycle.
- rise and fall are never both high on one channel.

Repeat (REPEAT_EN=1):
- Per-channel counter rc, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- rc clears when level[i] is 0, and also on the rise edge.
- While level[i] is 1, rc increments each cycle.
- The first rpt fires when rc reaches REPEAT_DELAY-1, that is, REPEAT_DELAY cycles after the rise pulse. rc then reloads 0 and the channel enters period mode.
- In period mode, rpt fires every REPEAT_PERIOD cycles.
- A release (fall) ends repeats immediately. No rpt is asserted on or after the fall edge.
- The rise pulse itself is not a repeat. rpt never coincides with rise.
- REPEAT_EN=0: rpt constant 0 and repeat logic removed.

Channels:
- Fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.

Test Plan:
1. N_CH=4, STABLE_CYCLES=8. Reset, then btn=4'b0001 clean step sampled at edge k -> level[0]=1 and rise[0]=1 at edge k+9 for one cycle; other bits stay 0.
2. Glitch rejection: btn[1] high for 7 cycles then low (STABLE_CYCLES=8) -> level[1], rise[1], fall[1] never assert. A following 8-cycle-high run -> rise[1] fires.
3. Bounce then settle: btn[2] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one rise[2], 9 edges after the final settle sample. Release with bounce -> exactly one fall[2].
4. Repeat: REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold btn[3] -> rise[3] at cycle T, rpt[3] at T+20, T+25, T+30, ... Release -> rpt stops; fall[3] with no rpt on or after it.
5. Simultaneous: btn=4'b1111 step -> rise=4'b1111 in a single cycle. Then btn=4'b0101 -> fall=4'b1010 in a single cycle, level=4'b0101.
6. Async reset mid-operation: assert reset between clock edges with cnt[0]=5 and level[3]=1 -> all outputs 0 immediately. With btn still 4'b1000 after release, level[3] re-rises 9 edges after the first post-reset sample, with a rise pulse.
